// File: rtl/envio_medidas_serial_if.sv
// Measurement hand-off between the DHT11 reader (master) and the serial
// sender (slave): trigger/error levels, readings, and the sender's status.
interface envio_medidas_serial_if;
    logic        pronto_medida;
    logic        erro;
    logic [15:0] temperatura;
    logic [15:0] umidade;
    logic        ocupado;
    logic        fim_envio;

    modport master (
        output pronto_medida, erro, temperatura, umidade,
        input  ocupado, fim_envio
    );

    modport slave (
        input  pronto_medida, erro, temperatura, umidade,
        output ocupado, fim_envio
    );
endinterface

// File: rtl/envio_medidas_serial.sv
// Formats a DHT11 reading (or an error notice) as ASCII text and sends it
// on a UART TX line, 8N1, LSB first.
module envio_medidas_serial #(
    parameter int unsigned CICLOS_BIT = 434
) (
    input  logic                  clock,
    input  logic                  reset,
    envio_medidas_serial_if.slave med,
    output logic                  saida_serial,
    output logic [3:0]            db_estado
);

    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        CARREGA = 4'd1,
        INICIO  = 4'd2,
        DADOS   = 4'd3,
        PARADA  = 4'd4,
        PROXIMO = 4'd5,
        FIM     = 4'd6
    } estado_t;

    localparam logic [15:0] ULTIMO_CICLO = 16'(CICLOS_BIT - 1);
    localparam logic [15:0] PENULT_CICLO = 16'(CICLOS_BIT - 2);

    estado_t     estado, prox_estado;
    logic        erro_ant;
    logic        tipo_erro;
    logic [15:0] temp_lat, umid_lat;
    logic [15:0] cont_bit;
    logic [2:0]  idx_bit;
    logic [3:0]  idx_byte;
    logic [7:0]  byte_atual;
    logic        borda_erro, disparo, fim_bit, fim_parada, ultimo_byte;

    function automatic logic [7:0] dezena(input logic [7:0] v);
        logic [7:0] s;
        s = (v > 8'd99) ? 8'd99 : v;
        return 8'h30 + s / 8'd10;
    endfunction

    function automatic logic [7:0] unidade(input logic [7:0] v);
        logic [7:0] s;
        s = (v > 8'd99) ? 8'd99 : v;
        return 8'h30 + s % 8'd10;
    endfunction

    function automatic logic [7:0] decimal(input logic [7:0] v);
        return 8'h30 + ((v > 8'd9) ? 8'd9 : v);
    endfunction

    assign borda_erro  = med.erro & ~erro_ant;
    assign disparo     = med.pronto_medida | borda_erro;
    assign fim_bit     = (cont_bit == ULTIMO_CICLO);
    // The last stop-bit cycle is spent in PROXIMO, so PARADA is one cycle short.
    assign fim_parada  = (cont_bit == PENULT_CICLO);
    assign ultimo_byte = (idx_byte == (tipo_erro ? 4'd4 : 4'd11));

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        byte_atual = 8'h0A;
        if (tipo_erro) begin
            case (idx_byte)
                4'd0:    byte_atual = 8'h45;
                4'd1:    byte_atual = 8'h52;
                4'd2:    byte_atual = 8'h52;
                4'd3:    byte_atual = 8'h4F;
                default: byte_atual = 8'h0A;
            endcase
        end else begin
            case (idx_byte)
                4'd0:    byte_atual = 8'h54;
                4'd1:    byte_atual = dezena(temp_lat[15:8]);
                4'd2:    byte_atual = unidade(temp_lat[15:8]);
                4'd3:    byte_atual = 8'h2E;
                4'd4:    byte_atual = decimal(temp_lat[7:0]);
                4'd5:    byte_atual = 8'h20;
                4'd6:    byte_atual = 8'h55;
                4'd7:    byte_atual = dezena(umid_lat[15:8]);
                4'd8:    byte_atual = unidade(umid_lat[15:8]);
                4'd9:    byte_atual = 8'h2E;
                4'd10:   byte_atual = decimal(umid_lat[7:0]);
                default: byte_atual = 8'h0A;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) estado <= OCIOSO;
        else        estado <= prox_estado;
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:  if (disparo) prox_estado = CARREGA;
            CARREGA: prox_estado = INICIO;
            INICIO:  if (fim_bit) prox_estado = DADOS;
            DADOS:   if (fim_bit && idx_bit == 3'd7) prox_estado = PARADA;
            PARADA:  if (fim_parada) prox_estado = PROXIMO;
            PROXIMO: prox_estado = ultimo_byte ? FIM : INICIO;
            FIM:     prox_estado = OCIOSO;
            default: prox_estado = OCIOSO;
        endcase
    end

    // NOTE: latched readings are reset too; cheap here and keeps the debug view deterministic.
    always_ff @(posedge clock) begin
        if (!reset) begin
            erro_ant  <= 1'b0;
            tipo_erro <= 1'b0;
            temp_lat  <= '0;
            umid_lat  <= '0;
            cont_bit  <= '0;
            idx_bit   <= '0;
            idx_byte  <= '0;
        end else begin
            erro_ant <= med.erro;
            case (estado)
                OCIOSO: begin
                    cont_bit <= '0;
                    idx_bit  <= '0;
                    idx_byte <= '0;
                    if (disparo) begin
                        temp_lat  <= med.temperatura;
                        umid_lat  <= med.umidade;
                        tipo_erro <= borda_erro;
                    end
                end
                INICIO: cont_bit <= fim_bit ? '0 : cont_bit + 16'd1;
                DADOS: begin
                    if (fim_bit) begin
                        cont_bit <= '0;
                        idx_bit  <= idx_bit + 3'd1;
                    end else begin
                        cont_bit <= cont_bit + 16'd1;
                    end
                end
                PARADA: cont_bit <= fim_parada ? '0 : cont_bit + 16'd1;
                PROXIMO: begin
                    cont_bit <= '0;
                    if (!ultimo_byte) idx_byte <= idx_byte + 4'd1;
                end
                default: cont_bit <= '0;
            endcase
        end
    end

    always_comb begin
        saida_serial = 1'b1;
        case (estado)
            INICIO:  saida_serial = 1'b0;
            DADOS:   saida_serial = byte_atual[idx_bit];
            default: saida_serial = 1'b1;
        endcase
        med.ocupado   = (estado != OCIOSO);
        med.fim_envio = (estado == FIM);
        db_estado     = estado;
    end

endmodule

// File: tb/tb_envio_medidas_serial.sv
// Directed and randomized frames checked against a byte-level model of the
// expected text and the 8N1 waveform it implies.
module tb_envio_medidas_serial;

    localparam int N = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       saida_serial;
    logic [3:0] db_estado;

    envio_medidas_serial_if med();

    envio_medidas_serial #(.CICLOS_BIT(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .med          (med),
        .saida_serial (saida_serial),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_bytes[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Status word: {line, busy, done pulse, debug state}.
    function automatic logic [31:0] status();
        return {25'd0, saida_serial, med.ocupado, med.fim_envio, db_estado};
    endfunction

    task automatic model_data(input logic [15:0] t, input logic [15:0] u);
        int ti, td, ui, ud;
        ti = (t[15:8] > 99) ? 99 : int'(t[15:8]);
        td = (t[7:0] > 9) ? 9 : int'(t[7:0]);
        ui = (u[15:8] > 99) ? 99 : int'(u[15:8]);
        ud = (u[7:0] > 9) ? 9 : int'(u[7:0]);
        exp_bytes = {8'h54, 8'(48 + ti / 10), 8'(48 + ti % 10), 8'h2E, 8'(48 + td), 8'h20,
                     8'h55, 8'(48 + ui / 10), 8'(48 + ui % 10), 8'h2E, 8'(48 + ud), 8'h0A};
    endtask

    // Call at the negedge where the trigger has just been applied; returns at
    // the negedge of the first idle cycle after the frame.
    task automatic run_frame(input string tag, input int inject_at);
        logic       line_q[$];
        int         mism, fims, idles, nb, idx;
        logic       e;
        logic [7:0] got;
        mism  = 0;
        fims  = 0;
        idles = 0;
        nb    = exp_bytes.size();
        @(negedge clock);
        med.pronto_medida = 1'b0;
        check({tag, " carrega"}, status(), 32'b1100001);
        for (int i = 0; i < nb * 10 * N; i++) begin
            @(negedge clock);
            line_q.push_back(saida_serial);
            if (med.fim_envio) fims++;
            if (!med.ocupado) idles++;
            med.temperatura   = 16'($urandom);
            med.umidade       = 16'($urandom);
            med.pronto_medida = (i == inject_at);
        end
        med.pronto_medida = 1'b0;
        for (int b = 0; b < nb; b++) begin
            for (int p = 0; p < 10; p++) begin
                e = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : exp_bytes[b][p-1];
                for (int c = 0; c < N; c++) begin
                    idx = (b * 10 + p) * N + c;
                    if (line_q[idx] !== e) mism++;
                end
            end
        end
        check({tag, " forma de onda"}, mism, 0);
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < 8; k++) got[k] = line_q[(b * 10 + k + 1) * N + N / 2];
            check($sformatf("%s byte %0d", tag, b), got, exp_bytes[b]);
        end
        check({tag, " fim antecipado"}, fims, 0);
        check({tag, " ocioso no quadro"}, idles, 0);
        @(negedge clock);
        check({tag, " fim"}, status(), 32'b1110110);
        @(negedge clock);
        check({tag, " ocioso"}, status(), 32'b1000000);
    endtask

    initial begin
        int busy, fims;
        logic [15:0] t, u;

        reset             = 1'b0;
        med.pronto_medida = 1'b0;
        med.erro          = 1'b0;
        med.temperatura   = '0;
        med.umidade       = '0;
        repeat (3) @(negedge clock);
        check("reset", status(), 32'b1000000);
        reset = 1'b1;
        @(negedge clock);
        check("pos reset", status(), 32'b1000000);

        med.temperatura   = 16'h1903;
        med.umidade       = 16'h3C00;
        med.pronto_medida = 1'b1;
        exp_bytes = {8'h54, 8'h32, 8'h35, 8'h2E, 8'h33, 8'h20,
                     8'h55, 8'h36, 8'h30, 8'h2E, 8'h30, 8'h0A};
        run_frame("dados", -1);

        // Trigger in the very first idle cycle: back-to-back frame.
        med.temperatura   = 16'h7F0C;
        med.umidade       = 16'h0505;
        med.pronto_medida = 1'b1;
        exp_bytes = {8'h54, 8'h39, 8'h39, 8'h2E, 8'h39, 8'h20,
                     8'h55, 8'h30, 8'h35, 8'h2E, 8'h35, 8'h0A};
        run_frame("saturacao", -1);
        repeat (3) @(negedge clock);

        t = {8'($urandom_range(0, 120)), 8'($urandom_range(0, 12))};
        u = {8'($urandom_range(0, 120)), 8'($urandom_range(0, 12))};
        med.temperatura   = t;
        med.umidade       = u;
        med.pronto_medida = 1'b1;
        model_data(t, u);
        run_frame("ignora ocupado", 50);
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (med.ocupado) busy++;
        end
        check("sem fila", busy, 0);

        med.erro  = 1'b1;
        exp_bytes = {8'h45, 8'h52, 8'h52, 8'h4F, 8'h0A};
        run_frame("erro", -1);
        busy = 0;
        for (int i = 0; i < 790; i++) begin
            @(negedge clock);
            if (med.ocupado) busy++;
        end
        check("erro sem repeticao", busy, 0);
        med.erro = 1'b0;
        repeat (2) @(negedge clock);

        med.erro          = 1'b1;
        med.pronto_medida = 1'b1;
        med.temperatura   = 16'h1505;
        exp_bytes = {8'h45, 8'h52, 8'h52, 8'h4F, 8'h0A};
        run_frame("prioridade erro", -1);
        med.erro = 1'b0;
        repeat (2) @(negedge clock);

        for (int k = 0; k < 4; k++) begin
            t = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 15))};
            u = {8'($urandom_range(0, 110)), 8'($urandom_range(0, 11))};
            med.temperatura   = t;
            med.umidade       = u;
            med.pronto_medida = 1'b1;
            model_data(t, u);
            run_frame($sformatf("aleatorio %0d", k), -1);
            repeat (k) @(negedge clock);
        end

        // Abort during the third byte, with a trigger coinciding with reset.
        med.temperatura   = 16'h2002;
        med.pronto_medida = 1'b1;
        @(negedge clock);
        med.pronto_medida = 1'b0;
        repeat (91) @(negedge clock);
        check("antes do reset", {31'd0, med.ocupado}, 32'd1);
        reset             = 1'b0;
        med.pronto_medida = 1'b1;
        @(negedge clock);
        check("reset no quadro", status(), 32'b1000000);
        reset             = 1'b1;
        med.pronto_medida = 1'b0;
        @(negedge clock);
        check("disparo descartado", status(), 32'b1000000);
        busy = 0;
        fims = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (med.ocupado) busy++;
            if (med.fim_envio) fims++;
        end
        check("sem fim apos reset", fims, 0);
        check("ocioso apos reset", busy, 0);

        t = {8'($urandom_range(0, 99)), 8'($urandom_range(0, 9))};
        u = {8'($urandom_range(0, 99)), 8'($urandom_range(0, 9))};
        med.temperatura   = t;
        med.umidade       = u;
        med.pronto_medida = 1'b1;
        model_data(t, u);
        run_frame("recupera", -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
